// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: serves 32-bit words from one cached L1-I line
// and issues a line-aligned refill request whenever the fetch PC leaves that line.
module fetch_line_buffer #(
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BITS  = 512
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] entry,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] S_R_ADDR,
  output logic                  S_R_ADDR_VALID,
  input  logic [LINE_BITS-1:0]  S_R_DATA,
  input  logic                  S_R_DATA_VALID
);

  localparam int OFFSET_BITS = 6;
  localparam int TAG_BITS    = ADDR_WIDTH - OFFSET_BITS;

  typedef enum logic {SERVE, MISS} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LINE_BITS-1:0]  line;
  logic [TAG_BITS-1:0]   line_tag;
  logic                  line_valid;
  logic                  discard;
  logic                  hit;
  logic [3:0]            word_idx;

  assign hit      = line_valid && (line_tag == fetch_pc[ADDR_WIDTH-1:OFFSET_BITS]);
  assign word_idx = fetch_pc[5:2];

  // Outputs are forced to their reset values combinationally so they are clean
  // even in the cycle reset first rises.
  assign out_valid      = !reset && (state == SERVE) && hit && !redirect_valid && !flush;
  assign out_instr      = line[{word_idx, 5'b00000} +: 32];
  assign out_pc         = reset ? entry : fetch_pc;
  assign S_R_ADDR_VALID = !reset && (state == MISS);
  assign S_R_ADDR       = reset ? '0 : req_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= entry;
      line_valid <= 1'b0;
      discard    <= 1'b0;
      state      <= SERVE;
      req_addr   <= '0;
    end else begin
      if (redirect_valid)
        fetch_pc <= redirect_pc & ~(ADDR_WIDTH'(3));
      else if (out_valid && out_ready)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);

      case (state)
        SERVE: begin
          if (!hit && !redirect_valid && !flush) begin
            state    <= MISS;
            req_addr <= {fetch_pc[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
          end
        end
        MISS: begin
          // A redirect never cancels the request; the line is installed under
          // its own tag and the new PC simply misses or hits against it.
          if (S_R_DATA_VALID) begin
            line       <= S_R_DATA;
            line_tag   <= req_addr[ADDR_WIDTH-1:OFFSET_BITS];
            line_valid <= !discard;
            discard    <= 1'b0;
            state      <= SERVE;
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        default: state <= SERVE;
      endcase

      // Flush wins over a same-cycle install so stale data is never served.
      if (flush) line_valid <= 1'b0;
    end
  end

endmodule
